// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: control-unit hooks, instruction-memory request/response, decoded-stage output.
// master = fetch unit, slave = control unit / memory / PD environment.
interface fetch_unit_if;
  logic        stall_if;
  logic        fence_i;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_rd;
  logic [63:0] imem_addr;
  logic        imem_busy;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] ir_if;
  logic [63:0] pc_if;
  logic        ir_valid;

  modport master (
    input  stall_if, fence_i, redirect, redirect_pc, imem_busy, imem_valid, imem_rdata,
    output imem_rd, imem_addr, ir_if, pc_if, ir_valid
  );

  modport slave (
    output stall_if, fence_i, redirect, redirect_pc, imem_busy, imem_valid, imem_rdata,
    input  imem_rd, imem_addr, ir_if, pc_if, ir_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: in-order requests, 2-entry {pc,word} queue; word visible one edge after its response.
// Credit-limited to queued + in-flight <= DEPTH; head held by stall_if; redirect/fence flush with stale-response discard.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DEPTH    = 2
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [63:0] r_pc;
  logic [63:0] r_q_pc  [2];
  logic [31:0] r_q_dat [2];
  logic        r_head;
  logic [1:0]  r_cnt;
  logic [1:0]  r_inflight;
  logic [1:0]  r_discard;
  logic        r_fence_d;
  logic [63:0] r_req_pc [2];
  logic        r_req_wr;
  logic        r_req_rd;

  logic        w_pop;
  logic        w_acc;
  logic        w_resp;
  logic        w_push;
  logic        w_fence_fall;
  logic        w_tail;
  logic [1:0]  w_cnt_after_pop;
  logic [2:0]  w_used;

  // A pop this cycle frees its slot immediately, which sustains one fetch per cycle at k=1.
  assign w_pop           = (r_cnt != 2'd0) && !bus.stall_if;
  assign w_cnt_after_pop = r_cnt - {1'b0, w_pop};
  assign w_used          = {1'b0, w_cnt_after_pop} + {1'b0, r_inflight};
  assign w_fence_fall    = r_fence_d && !bus.fence_i;

  assign bus.imem_rd   = !rst && !bus.redirect && !bus.fence_i && (w_used < 3'(DEPTH));
  assign bus.imem_addr = r_pc;

  assign w_acc  = bus.imem_rd && !bus.imem_busy;
  assign w_resp = bus.imem_valid;
  assign w_push = w_resp && (r_discard == 2'd0) && !bus.redirect && !w_fence_fall;
  assign w_tail = r_head ^ r_cnt[0];

  assign bus.ir_valid = (r_cnt != 2'd0);
  assign bus.ir_if    = bus.ir_valid ? r_q_dat[r_head] : NOP;
  assign bus.pc_if    = bus.ir_valid ? r_q_pc[r_head]  : r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_head     <= 1'b0;
      r_cnt      <= 2'd0;
      r_inflight <= 2'd0;
      r_discard  <= 2'd0;
      r_fence_d  <= 1'b0;
      r_req_wr   <= 1'b0;
      r_req_rd   <= 1'b0;
    end else begin
      r_fence_d  <= bus.fence_i;
      r_inflight <= r_inflight + {1'b0, w_acc} - {1'b0, w_resp};
      if (w_acc) begin
        r_req_pc[r_req_wr] <= r_pc;
        r_req_wr           <= ~r_req_wr;
      end
      if (w_resp) begin
        r_req_rd <= ~r_req_rd;
      end

      if (bus.redirect) begin
        r_cnt     <= 2'd0;
        r_pc      <= bus.redirect_pc & ~64'h3;
        r_discard <= r_inflight - {1'b0, w_resp};
      end else if (w_fence_fall) begin
        // Everything fetched past the FENCE.I is stale: keep only the head, refetch from head+4.
        r_cnt     <= ((r_cnt != 2'd0) && !w_pop) ? 2'd1 : 2'd0;
        r_discard <= r_inflight + {1'b0, w_acc} - {1'b0, w_resp};
        if (w_pop) begin
          r_head <= ~r_head;
        end
        if (r_cnt != 2'd0) begin
          r_pc <= r_q_pc[r_head] + 64'd4;
        end else if (w_acc) begin
          r_pc <= r_pc + 64'd4;
        end
      end else begin
        if (w_acc) begin
          r_pc <= r_pc + 64'd4;
        end
        if (w_push) begin
          r_q_pc[w_tail]  <= r_req_pc[r_req_rd];
          r_q_dat[w_tail] <= bus.imem_rdata;
        end
        if (w_pop) begin
          r_head <= ~r_head;
        end
        r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        if (w_resp && (r_discard != 2'd0)) begin
          r_discard <= r_discard - 2'd1;
        end
      end
    end
  end

  a_resp_has_credit: assert property (@(posedge clk) disable iff (rst)
    bus.imem_valid |-> (r_inflight != 2'd0));
  a_counts_bounded: assert property (@(posedge clk) disable iff (rst)
    (r_inflight <= 2'd2) && (r_discard <= r_inflight) && (r_cnt <= 2'd2));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural in-order memory with programmable latency, addr-tagged words.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   lat      = 1;

  typedef struct {
    int          due;
    logic [63:0] addr;
  } req_t;
  req_t mem_q[$];

  fetch_unit_if bus ();
  fetch_unit_if wbus ();

  fetch_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic tick();
    req_t r;
    #1;
    if (bus.imem_rd && !bus.imem_busy) begin
      r.due  = cyc + lat;
      r.addr = bus.imem_addr;
      mem_q.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;
    if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
      bus.imem_valid = 1'b1;
      bus.imem_rdata = mem_q[0].addr[31:0];
      mem_q.delete(0);
    end
  endtask

  task automatic do_reset(input int l);
    rst             = 1'b1;
    lat             = l;
    mem_q.delete();
    bus.stall_if    = 1'b0;
    bus.fence_i     = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_busy   = 1'b0;
    bus.imem_valid  = 1'b0;
    bus.imem_rdata  = '0;
    tick();
    tick();
    #1;
    chk("rst_imem_rd", 64'(bus.imem_rd), 64'd0);
    chk("rst_ir_valid", 64'(bus.ir_valid), 64'd0);
    chk("rst_ir_if", 64'(bus.ir_if), 64'h13);
    chk("rst_pc_if", bus.pc_if, 64'h8000_0000);
    rst = 1'b0;
    cyc = 1;
  endtask

  initial begin
    logic [63:0] e;
    wbus.stall_if    = 1'b0;
    wbus.fence_i     = 1'b0;
    wbus.redirect    = 1'b0;
    wbus.redirect_pc = '0;
    wbus.imem_busy   = 1'b0;
    wbus.imem_valid  = 1'b0;
    wbus.imem_rdata  = '0;

    // Streaming at k=1, then a 5-cycle stall
    do_reset(1);
    #1;
    chk("c1_rd", 64'(bus.imem_rd), 64'd1);
    chk("c1_addr", bus.imem_addr, 64'h8000_0000);
    chk("wrap_c1_addr", wbus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    #1;
    chk("c2_addr", bus.imem_addr, 64'h8000_0004);
    chk("c2_ir_valid", 64'(bus.ir_valid), 64'd0);
    chk("wrap_c2_rd", 64'(wbus.imem_rd), 64'd1);
    chk("wrap_c2_addr", wbus.imem_addr, 64'h0);
    tick();
    #1;
    chk("c3_addr", bus.imem_addr, 64'h8000_0008);
    for (int i = 0; i < 3; i++) begin
      e = 64'h8000_0000 + 64'(4 * i);
      chk("stream_valid", 64'(bus.ir_valid), 64'd1);
      chk("stream_pc", bus.pc_if, e);
      chk("stream_ir", 64'(bus.ir_if), 64'(e[31:0]));
      if (i < 2) begin
        tick();
        #1;
      end
    end
    bus.stall_if = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_rd", 64'(bus.imem_rd), 64'd0);
      chk("stall_head", bus.pc_if, 64'h8000_0008);
      tick();
    end
    bus.stall_if = 1'b0;
    #1;
    chk("release_rd", 64'(bus.imem_rd), 64'd1);
    chk("release_addr", bus.imem_addr, 64'h8000_0010);
    for (int i = 0; i < 4; i++) begin
      e = 64'h8000_0008 + 64'(4 * i);
      chk("release_valid", 64'(bus.ir_valid), 64'd1);
      chk("release_pc", bus.pc_if, e);
      chk("release_ir", 64'(bus.ir_if), 64'(e[31:0]));
      tick();
      #1;
    end

    // Redirect with two requests in flight on a 3-cycle memory (reset mid-operation)
    do_reset(3);
    tick();
    tick();
    #1;
    chk("rd_full_credit", 64'(bus.imem_rd), 64'd0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h8000_1003;
    #1;
    chk("redir_cycle_rd", 64'(bus.imem_rd), 64'd0);
    tick();
    bus.redirect = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      #1;
      chk("redir_drop_valid", 64'(bus.ir_valid), 64'd0);
      if (c == 5) begin
        chk("redir_rd", 64'(bus.imem_rd), 64'd1);
        chk("redir_addr", bus.imem_addr, 64'h8000_1000);
      end
      tick();
    end
    #1;
    chk("redir_valid", 64'(bus.ir_valid), 64'd1);
    chk("redir_pc", bus.pc_if, 64'h8000_1000);
    chk("redir_ir", 64'(bus.ir_if), 64'h8000_1000);

    // FENCE.I at 0x8000_0010 held for 4 cycles
    do_reset(1);
    for (int i = 0; i < 6; i++) tick();
    #1;
    chk("fence_head", bus.pc_if, 64'h8000_0010);
    bus.stall_if = 1'b1;
    bus.fence_i  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fence_rd", 64'(bus.imem_rd), 64'd0);
      chk("fence_hold", bus.pc_if, 64'h8000_0010);
      tick();
    end
    bus.fence_i = 1'b0;
    #1;
    chk("fence_fall_rd", 64'(bus.imem_rd), 64'd0);
    tick();
    bus.stall_if = 1'b0;
    #1;
    chk("fence_post_pc", bus.pc_if, 64'h8000_0010);
    chk("fence_post_rd", 64'(bus.imem_rd), 64'd1);
    chk("fence_post_addr", bus.imem_addr, 64'h8000_0014);
    tick();
    #1;
    chk("fence_dropped", 64'(bus.ir_valid), 64'd0);
    tick();
    #1;
    chk("fence_refetch_pc", bus.pc_if, 64'h8000_0014);
    chk("fence_refetch_ir", 64'(bus.ir_if), 64'h8000_0014);

    // Redirect coinciding with fence falling edge and a pop
    do_reset(1);
    for (int i = 0; i < 6; i++) tick();
    bus.stall_if = 1'b1;
    bus.fence_i  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.fence_i     = 1'b0;
    bus.stall_if    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h8000_2000;
    #1;
    chk("rf_cycle_rd", 64'(bus.imem_rd), 64'd0);
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("rf_empty", 64'(bus.ir_valid), 64'd0);
    chk("rf_addr", bus.imem_addr, 64'h8000_2000);
    tick();
    #1;
    chk("rf_empty2", 64'(bus.ir_valid), 64'd0);
    tick();
    #1;
    chk("rf_pc", bus.pc_if, 64'h8000_2000);
    chk("rf_valid", 64'(bus.ir_valid), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
